// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit buffer between the host register block and the UART core
// transmitter. Host bytes are stored in a circular FIFO. The launcher takes one
// byte at a time from the head, presents it zero-extended on tx_data_o with a
// one-cycle start_tx_o pulse, and then waits for the core's tx_done_i pulse
// before it launches the next byte.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   wr_en_i     host write strobe, one byte per cycle
//   wr_data_i   host write byte
//   flush_i     synchronous clear of all stored entries
//   tx_en_i     launch enable; bytes are held in the FIFO while low
//   ovf_clr_i   clears the sticky overflow flag
//   tx_done_i   one-cycle frame-complete pulse from the core
//   tx_data_o   data word to the core, {zeros, byte}
//   start_tx_o  one-cycle launch pulse to the core
//   tx_busy_o   high while a launched frame has not yet reported done
//   full_o      stored count equals DEPTH
//   empty_o     stored count equals zero
//   count_o     number of stored entries
//   overflow_o  sticky; set by a write attempted while full
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       flush_i,
    input  logic                       tx_en_i,
    input  logic                       ovf_clr_i,
    input  logic                       tx_done_i,
    output logic [31:0]                tx_data_o,
    output logic                       start_tx_o,
    output logic                       tx_busy_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Storage array; written only, read through the launch register.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [0:0]    state_q,   state_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0] count_q,   count_d;
    logic          full_q,    full_d;
    logic          empty_q,   empty_d;
    logic          ovf_q,     ovf_d;
    logic          start_q,   start_d;
    logic          busy_q,    busy_d;
    logic [31:0]   tx_data_q, tx_data_d;

    logic wr_accept;
    logic pop;

    // Full is judged on the registered flag, so a pop in the same cycle does
    // not open a slot for the write.
    assign wr_accept = wr_en_i && !full_q;

    // Flush suppresses any launch in its cycle.
    assign pop = (state_q == ST_IDLE) && tx_en_i && !empty_q && !flush_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_data_d = tx_data_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                tx_data_d = 32'(mem_q[rd_ptr_q]);
            end
            case ({wr_accept, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // Sticky overflow: a new overflow event beats a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en_i && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // Launcher. A flush does not disturb WAIT: the frame already handed to
    // the core still has to report done, and its data stays on tx_data_o.
    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_i) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign start_tx_o = start_q;
    assign tx_busy_o  = busy_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Randomised and directed stimulus for uart_tx_fifo. A reference model (a byte
// queue plus a busy flag) steps on every rising edge from the sampled inputs
// and pushes each byte it expects to be launched into a scoreboard queue. A
// monitor on the falling edge compares the DUT status outputs with the model
// and pops the scoreboard whenever the DUT presents a start pulse. A responder
// returns tx_done_i a programmable number of cycles after each start.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              flush_i;
    logic              tx_en_i;
    logic              ovf_clr_i;
    logic              tx_done_i;
    logic [31:0]       tx_data_o;
    logic              start_tx_o;
    logic              tx_busy_o;
    logic              full_o;
    logic              empty_o;
    logic [CW-1:0]     count_o;
    logic              overflow_o;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .flush_i    (flush_i),
        .tx_en_i    (tx_en_i),
        .ovf_clr_i  (ovf_clr_i),
        .tx_done_i  (tx_done_i),
        .tx_data_o  (tx_data_o),
        .start_tx_o (start_tx_o),
        .tx_busy_o  (tx_busy_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_q [$];   // bytes stored, oldest first
    logic [DATA_W-1:0] sb  [$];   // bytes expected on upcoming start pulses
    bit          m_busy = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          m_start = 1'b0;
    logic [31:0] m_data = '0;
    int          cyc = 0;
    int          last_done_cyc = -1;

    initial begin
        forever begin
            bit full, emp, pop;
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                sb.delete();
                m_busy  = 1'b0;
                m_ovf   = 1'b0;
                m_start = 1'b0;
                m_data  = '0;
            end else begin
                cyc++;
                full = (m_q.size() == DEPTH);
                emp  = (m_q.size() == 0);
                pop  = !m_busy && tx_en_i && !emp && !flush_i;
                if (wr_en_i && full) m_ovf = 1'b1;
                else if (ovf_clr_i)  m_ovf = 1'b0;
                m_start = pop;
                if (flush_i) begin
                    m_q.delete();
                end else begin
                    if (pop) begin
                        m_data = 32'(m_q.pop_front());
                        sb.push_back(m_data[DATA_W-1:0]);
                    end
                    if (wr_en_i && !full) m_q.push_back(wr_data_i);
                end
                if (pop) begin
                    m_busy = 1'b1;
                end else if (m_busy && tx_done_i) begin
                    m_busy = 1'b0;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit mon_en = 1'b0;
    int launches = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mon_count",    64'(count_o),    64'(m_q.size()));
                chk("mon_empty",    64'(empty_o),    64'(m_q.size() == 0));
                chk("mon_full",     64'(full_o),     64'(m_q.size() == DEPTH));
                chk("mon_overflow", 64'(overflow_o), 64'(m_ovf));
                chk("mon_busy",     64'(tx_busy_o),  64'(m_busy));
                chk("mon_start",    64'(start_tx_o), 64'(m_start));
                chk("mon_txdata",   64'(tx_data_o),  64'(m_data));
                if (start_tx_o) begin
                    launches++;
                    chk("launch_spacing", 64'(cyc > last_done_cyc), 64'(1));
                    if (sb.size() == 0) begin
                        chk("launch_unexpected", 64'(tx_data_o), 64'hDEAD_0000);
                    end else begin
                        logic [DATA_W-1:0] e;
                        e = sb.pop_front();
                        chk("launch_data", 64'(tx_data_o), 64'(e));
                        $display("launch %0d: data=%08h expected=%02h", launches, tx_data_o, e);
                    end
                end
            end
        end
    end

    // ---------------- core responder ----------------
    int resp_delay = 3;
    int stray_req  = 0;

    initial begin
        int dc;
        int stray_seen;
        dc = 0;
        stray_seen = 0;
        tx_done_i = 1'b0;
        forever begin
            @(negedge clk);
            tx_done_i = 1'b0;
            if (rst) begin
                dc = 0;
            end else if (dc > 0) begin
                dc--;
                if (dc == 0) tx_done_i = 1'b1;
            end else if (start_tx_o) begin
                dc = resp_delay;
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                tx_done_i  = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [DATA_W-1:0] b);
        wr_en_i   = 1'b1;
        wr_data_i = b;
        @(negedge clk);
        wr_en_i   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles; i++) begin
            if (empty_o && !tx_busy_o) break;
            @(negedge clk);
        end
        chk(name, 64'({empty_o, tx_busy_o}), 64'(2'b10));
    endtask

    initial begin
        int base;
        rst = 1'b1;
        wr_en_i = 1'b0; wr_data_i = '0; flush_i = 1'b0;
        tx_en_i = 1'b0; ovf_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_empty", 64'(empty_o), 64'(1));
        chk("rst_full",  64'(full_o),  64'(0));
        chk("rst_start", 64'(start_tx_o), 64'(0));
        chk("rst_txdata", 64'(tx_data_o), 64'(0));

        // Single byte: count at write+1, start and data at write+2.
        tx_en_i = 1'b1;
        resp_delay = 4;
        wr(8'hA5);
        chk("t1_count_n1", 64'(count_o), 64'(1));
        chk("t1_start_n1", 64'(start_tx_o), 64'(0));
        @(negedge clk);
        chk("t1_start_n2", 64'(start_tx_o), 64'(1));
        chk("t1_data_n2",  64'(tx_data_o),  64'h0000_00A5);
        chk("t1_busy_n2",  64'(tx_busy_o),  64'(1));
        @(negedge clk);
        chk("t1_start_n3", 64'(start_tx_o), 64'(0));
        wait_idle(50, "t1_drain");

        // Fill, overflow, clear.
        tx_en_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) wr(DATA_W'(i));
        chk("t2_full",  64'(full_o),  64'(1));
        chk("t2_count", 64'(count_o), 64'(DEPTH));
        wr(8'hFF);
        chk("t2_ovf",       64'(overflow_o), 64'(1));
        chk("t2_count_ovf", 64'(count_o),    64'(DEPTH));
        ovf_clr_i = 1'b1;
        @(negedge clk);
        ovf_clr_i = 1'b0;
        chk("t2_ovf_clr", 64'(overflow_o), 64'(0));

        // Drain all 16 with a slow core.
        base = launches;
        resp_delay = 10;
        tx_en_i = 1'b1;
        wait_idle(400, "t3_drain");
        chk("t3_launches", 64'(launches - base), 64'(DEPTH));

        // Pointer wrap.
        resp_delay = 1;
        tx_en_i = 1'b0;
        for (int i = 0; i < 10; i++) wr(DATA_W'(8'h20 + i));
        tx_en_i = 1'b1;
        wait_idle(100, "t4_drain_a");
        tx_en_i = 1'b0;
        for (int i = 0; i < 10; i++) wr(DATA_W'(8'h40 + i));
        tx_en_i = 1'b1;
        wait_idle(100, "t4_drain_b");

        // Write and pop in the same cycle.
        tx_en_i = 1'b0;
        for (int i = 0; i < 3; i++) wr(DATA_W'(8'h60 + i));
        tx_en_i   = 1'b1;
        wr_en_i   = 1'b1;
        wr_data_i = 8'h63;
        @(negedge clk);
        wr_en_i = 1'b0;
        chk("t4_wr_pop_count", 64'(count_o), 64'(3));
        wait_idle(100, "t4_drain_c");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            wr_en_i    = 1'($urandom_range(0, 1));
            wr_data_i  = DATA_W'($urandom);
            tx_en_i    = ($urandom_range(0, 9) < 8);
            flush_i    = ($urandom_range(0, 39) == 0);
            ovf_clr_i  = ($urandom_range(0, 19) == 0);
            resp_delay = $urandom_range(1, 6);
            @(negedge clk);
        end
        wr_en_i = 1'b0; flush_i = 1'b0; ovf_clr_i = 1'b0;
        tx_en_i = 1'b1;
        wait_idle(400, "rand_drain");
        ovf_clr_i = 1'b1;
        @(negedge clk);
        ovf_clr_i = 1'b0;

        // Flush while a frame is outstanding with 5 bytes stored.
        tx_en_i = 1'b0;
        for (int i = 0; i < 6; i++) wr(DATA_W'(8'h80 + i));
        resp_delay = 8;
        tx_en_i = 1'b1;
        @(negedge clk);
        chk("t5_busy_pre",  64'(tx_busy_o), 64'(1));
        chk("t5_count_pre", 64'(count_o),   64'(5));
        base = launches;
        flush_i   = 1'b1;
        wr_en_i   = 1'b1;
        wr_data_i = 8'h77;
        @(negedge clk);
        flush_i = 1'b0;
        wr_en_i = 1'b0;
        chk("t5_count_flush", 64'(count_o),   64'(0));
        chk("t5_busy_flush",  64'(tx_busy_o), 64'(1));
        chk("t5_data_held",   64'(tx_data_o), 64'h0000_0080);
        wait_idle(50, "t5_done");
        repeat (6) @(negedge clk);
        chk("t5_no_launch", 64'(launches - base), 64'(0));

        // Reset while waiting with 3 bytes stored, then a stray done.
        tx_en_i = 1'b0;
        for (int i = 0; i < 4; i++) wr(DATA_W'(8'hC0 + i));
        resp_delay = 20;
        tx_en_i = 1'b1;
        @(negedge clk);
        chk("t6_busy_pre",  64'(tx_busy_o), 64'(1));
        chk("t6_count_pre", 64'(count_o),   64'(3));
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_count", 64'(count_o),    64'(0));
        chk("t6_rst_empty", 64'(empty_o),    64'(1));
        chk("t6_rst_busy",  64'(tx_busy_o),  64'(0));
        chk("t6_rst_data",  64'(tx_data_o),  64'(0));
        chk("t6_rst_ovf",   64'(overflow_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        base = launches;
        stray_req++;
        repeat (3) @(negedge clk);
        chk("t6_stray_busy",  64'(tx_busy_o),  64'(0));
        chk("t6_stray_count", 64'(count_o),    64'(0));
        chk("t6_stray_start", 64'(launches - base), 64'(0));

        chk("sb_empty", 64'(sb.size()), 64'(0));
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
